mem_burst_initiator: RTL and testbench

Initiator-side controller that drives the single-port synchronous memory interface: addr, data_in, write_enable, read_enable, data_out, with a one-cycle registered read. It accepts burst read and write commands from a host over a valid/ready handshake. It then sequences per-beat memory accesses with an incrementing, wrapping address, and returns read data over a valid/ready stream. It sits between a host agent and the memory array, and is the only block that drives the memory's control pins.

---
 rtl/mem_burst_initiator.sv | 124 ++++++++++++
 tb/tb_mem_burst_initiator.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_initiator.sv
// Burst command front-end for a single-port synchronous memory.
// Sequences per-beat writes and registered reads with a wrapping address.
module mem_burst_initiator #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RD_OUT
    } state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  cur_addr_q;
    logic [ADDR_W-1:0]  beats_left_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic               mem_we_q;
    logic [DATA_W-1:0]  rd_data_q;
    logic               rd_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            rd_data_q    <= '0;
            rd_last_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr_q   <= cmd_addr;
                        beats_left_q <= cmd_len;
                        if (cmd_write) begin
                            state_q <= WR;
                        end else begin
                            // address must be on the pins during RD_REQ
                            mem_addr_q <= cmd_addr;
                            state_q    <= RD_REQ;
                        end
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cur_addr_q;
                        mem_wdata_q <= wr_data;
                        cur_addr_q  <= cur_addr_q + ADDR_W'(1);
                        if (beats_left_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            beats_left_q <= beats_left_q - ADDR_W'(1);
                        end
                    end
                end
                RD_REQ: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    rd_data_q <= mem_rdata;
                    rd_last_q <= (beats_left_q == '0);
                    state_q   <= RD_OUT;
                end
                RD_OUT: begin
                    if (rd_ready) begin
                        if (rd_last_q) begin
                            state_q <= IDLE;
                        end else begin
                            cur_addr_q   <= cur_addr_q + ADDR_W'(1);
                            mem_addr_q   <= cur_addr_q + ADDR_W'(1);
                            beats_left_q <= beats_left_q - ADDR_W'(1);
                            state_q      <= RD_REQ;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WR);
    assign mem_re    = (state_q == RD_REQ);
    assign rd_valid  = (state_q == RD_OUT);
    assign busy      = (state_q != IDLE);

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Scoreboard bench for mem_burst_initiator with a behavioural memory.
// Directed bursts push expectations; a negedge monitor pops and compares.
module tb_mem_burst_initiator;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_last;
    logic       rd_ready;
    logic       busy;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int exp_acc  = 0;

    logic [11:0] wq[$];
    logic [3:0]  raq[$];
    logic [8:0]  rq[$];

    logic [7:0] mem[16];

    mem_burst_initiator #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-cycle registered read memory
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    always @(negedge clk) begin
        logic [11:0] we_e;
        logic [3:0]  re_e;
        logic [8:0]  rd_e;
        if (rst_n) begin
            if (cmd_valid && cmd_ready) n_acc++;
            if (mem_we || mem_re)
                chk("we_re_excl", 32'(mem_we & mem_re), 32'd0);
            if (mem_we) begin
                if (wq.size() == 0) begin
                    tmo("unexpected_write");
                end else begin
                    we_e = wq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(we_e[11:8]));
                    chk("wr_data", 32'(mem_wdata), 32'(we_e[7:0]));
                end
            end
            if (mem_re) begin
                if (raq.size() == 0) begin
                    tmo("unexpected_read");
                end else begin
                    re_e = raq.pop_front();
                    chk("rd_addr", 32'(mem_addr), 32'(re_e));
                end
            end
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) begin
                    tmo("unexpected_beat");
                end else begin
                    rd_e = rq.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(rd_e[7:0]));
                    chk("rd_last", 32'(rd_last), 32'(rd_e[8]));
                end
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [3:0] a,
                            input logic [3:0] l);
        int k;
        @(posedge clk); #1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        exp_acc++;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) tmo("cmd_accept");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [3:0] a, input int n,
                            input logic [31:0] dv);
        int k;
        for (int i = 0; i < n; i++) begin
            wr_data  = dv[8*i +: 8];
            wr_valid = 1'b1;
            wq.push_back({4'(a + 4'(i)), dv[8*i +: 8]});
            k = 0;
            do begin
                @(negedge clk);
                if (cmd_valid) chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                k++;
            end while (!wr_ready && k < 50);
            if (!wr_ready) tmo("wr_beat");
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_busy_fall", 32'(busy), 32'd0);
        chk("wr_last_we", 32'(mem_we), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) tmo("wait_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b1;

        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // single write then read
        send_cmd(1'b1, 4'd1, 4'd0);
        wr_burst(4'd1, 1, 32'h000000AA);
        raq.push_back(4'd1);
        rq.push_back({1'b1, 8'hAA});
        send_cmd(1'b0, 4'd1, 4'd0);
        @(negedge clk);
        chk("rd_lat_c1", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("rd_lat_c2", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("rd_lat_c3", 32'(rd_valid), 32'd1);
        wait_idle();

        // wrapping burst
        send_cmd(1'b1, 4'd14, 4'd3);
        wr_burst(4'd14, 4, 32'h44332211);
        raq.push_back(4'd14);
        raq.push_back(4'd15);
        raq.push_back(4'd0);
        raq.push_back(4'd1);
        rq.push_back({1'b0, 8'h11});
        rq.push_back({1'b0, 8'h22});
        rq.push_back({1'b0, 8'h33});
        rq.push_back({1'b1, 8'h44});
        send_cmd(1'b0, 4'd14, 4'd3);
        wait_idle();

        // write stalls: wr_valid 1,0,0,1
        send_cmd(1'b1, 4'd4, 4'd1);
        wq.push_back({4'd4, 8'h5A});
        wq.push_back({4'd5, 8'hC3});
        wr_data  = 8'h5A;
        wr_valid = 1'b1;
        @(negedge clk);
        chk("stall_wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("stall_we1", 32'(mem_we), 32'd1);
        chk("stall_busy1", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_gap_we", 32'(mem_we), 32'd0);
        chk("stall_busy2", 32'(busy), 32'd1);
        @(posedge clk); #1;
        wr_data  = 8'hC3;
        wr_valid = 1'b1;
        @(negedge clk);
        chk("stall_gap_we2", 32'(mem_we), 32'd0);
        chk("stall_busy3", 32'(busy), 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        chk("stall_busy_fall", 32'(busy), 32'd0);
        chk("stall_we2", 32'(mem_we), 32'd1);

        // read backpressure on beat 1
        raq.push_back(4'd4);
        raq.push_back(4'd5);
        rq.push_back({1'b0, 8'h5A});
        rq.push_back({1'b1, 8'hC3});
        rd_ready = 1'b0;
        send_cmd(1'b0, 4'd4, 4'd1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rd_valid), 32'd1);
            chk("bp_data", 32'(rd_data), 32'h5A);
            chk("bp_last", 32'(rd_last), 32'd0);
        end
        @(posedge clk); #1;
        rd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_b2_c1", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("bp_b2_c2", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("bp_b2_c3", 32'(rd_valid), 32'd1);
        wait_idle();

        // command held during a write burst, then read of last address
        send_cmd(1'b1, 4'd8, 4'd2);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd10;
        cmd_len   = 4'd0;
        raq.push_back(4'd10);
        rq.push_back({1'b1, 8'hA3});
        wr_burst(4'd8, 3, 32'h00A3A2A1);
        chk("held_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exp_acc++;
        wait_idle();

        // reset during RD_WAIT
        send_cmd(1'b1, 4'd9, 4'd0);
        wr_burst(4'd9, 1, 32'h0000005C);
        raq.push_back(4'd9);
        send_cmd(1'b0, 4'd9, 4'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_mem_re", 32'(mem_re), 32'd0);
        chk("mrst_mem_we", 32'(mem_we), 32'd0);
        chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mrst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("mrst_rd_data", 32'(rd_data), 32'd0);
        chk("mrst_rd_last", 32'(rd_last), 32'd0);
        chk("mrst_wr_ready", 32'(wr_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        raq.push_back(4'd9);
        rq.push_back({1'b1, 8'h5C});
        send_cmd(1'b0, 4'd9, 4'd0);
        wait_idle();

        @(negedge clk);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("raq_empty", 32'(raq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        chk("accept_count", 32'(n_acc), 32'(exp_acc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
